// File: rtl/deserializer_if.sv
// Output handshake bundle of the deserializer: received word, valid-bit count,
// and the valid/ready pair used to hand words to the consumer.
interface deser_if #(
  parameter int WIDTH   = 16,
  parameter int W_INDEX = $clog2(WIDTH)
);
  logic [WIDTH-1:0]   deser_data_o;
  logic [W_INDEX-1:0] deser_data_mod_o;
  logic               deser_data_val_o;
  logic               deser_data_rdy_i;

  modport master (
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o,
    input  deser_data_rdy_i
  );

  modport slave (
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o,
    output deser_data_rdy_i
  );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel converter: packs MSB-first bits into WIDTH-bit words,
// rejects 1- and 2-bit frames and buffers finished words in a 2-entry FIFO.
//
// state | meaning
// IDLE  | no bits held, bit counter is 0
// RECV  | 1..WIDTH-1 bits of the current frame held in the shift register
module deserializer #(
  parameter int WIDTH   = 16,
  parameter int W_INDEX = $clog2(WIDTH)
) (
  input  logic     clk_i,
  input  logic     srst_i,
  input  logic     data_i,
  input  logic     data_val_i,
  deser_if.master  deser,
  output logic     frame_err_o,
  output logic     ovf_o
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [W_INDEX-1:0] LAST_POS  = W_INDEX'(WIDTH - 1);
  localparam logic [W_INDEX-1:0] MIN_LEGAL = W_INDEX'(3);

  state_t             state;
  logic [W_INDEX-1:0] bit_cnt;
  logic [WIDTH-1:0]   shreg;

  logic [W_INDEX-1:0] bit_pos;
  logic [WIDTH-1:0]   word_nxt;
  logic               full_close;
  logic               short_close;
  logic               push;
  logic [WIDTH-1:0]   push_data;
  logic [W_INDEX-1:0] push_mod;

  logic [WIDTH-1:0]   fifo_data [2];
  logic [W_INDEX-1:0] fifo_mod  [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fifo_cnt;
  logic               fifo_nempty;
  logic               pop;
  logic               push_ok;

  // The shift register is cleared on every close, so unreceived low bits stay 0.
  always_comb begin
    bit_pos           = LAST_POS - bit_cnt;
    word_nxt          = shreg;
    word_nxt[bit_pos] = data_i;
    full_close        = data_val_i && (bit_cnt == LAST_POS);
    short_close       = (state == RECV) && !data_val_i;
    push              = full_close || (short_close && (bit_cnt >= MIN_LEGAL));
    push_data         = full_close ? word_nxt : shreg;
    push_mod          = full_close ? '0 : bit_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= short_close && (bit_cnt < MIN_LEGAL);
      if (full_close || short_close) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (data_val_i) begin
        state   <= RECV;
        bit_cnt <= bit_cnt + W_INDEX'(1);
        shreg   <= word_nxt;
      end
    end
  end

  assign fifo_nempty = (fifo_cnt != 2'd0);
  assign pop         = fifo_nempty && deser.deser_data_rdy_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok     = push && ((fifo_cnt != 2'd2) || pop);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      ovf_o    <= 1'b0;
    end else begin
      ovf_o <= push && !push_ok;
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_mod[wr_ptr]  <= push_mod;
    end
  end

  assign deser.deser_data_val_o = fifo_nempty;
  assign deser.deser_data_o     = fifo_nempty ? fifo_data[rd_ptr] : '0;
  assign deser.deser_data_mod_o = fifo_nempty ? fifo_mod[rd_ptr]  : '0;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: per-scenario tasks with hand-computed
// expected words; a negedge monitor logs every word handed to the consumer.
module tb_deserializer;
  localparam int WIDTH   = 16;
  localparam int W_INDEX = 4;

  logic clk = 1'b0;
  logic srst;
  logic data_i;
  logic data_val_i;
  logic frame_err;
  logic ovf;

  int vectors    = 0;
  int miscompares = 0;

  deser_if #(.WIDTH(WIDTH), .W_INDEX(W_INDEX)) dif ();

  deserializer #(.WIDTH(WIDTH), .W_INDEX(W_INDEX)) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .data_i      (data_i),
    .data_val_i  (data_val_i),
    .deser       (dif),
    .frame_err_o (frame_err),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  int               cyc = 0;
  logic [WIDTH-1:0] q_data [$];
  logic [3:0]       q_mod  [$];
  int               q_cyc  [$];
  int               err_cnt, ovf_cnt, val_cycles, zero_viol, last_err_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dif.deser_data_val_o && dif.deser_data_rdy_i) begin
      q_data.push_back(dif.deser_data_o);
      q_mod.push_back(dif.deser_data_mod_o);
      q_cyc.push_back(cyc);
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (ovf) ovf_cnt++;
    if (dif.deser_data_val_o) val_cycles++;
    if (dif.deser_data_val_o === 1'b0 &&
        (dif.deser_data_o !== '0 || dif.deser_data_mod_o !== '0)) zero_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_mod.delete();
    q_cyc.delete();
    err_cnt      = 0;
    ovf_cnt      = 0;
    val_cycles   = 0;
    last_err_cyc = -1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int n);
    logic [WIDTH-1:0] wv;
    wv = w;
    for (int i = 0; i < n; i++) begin
      data_i     = wv[WIDTH-1-i];
      data_val_i = 1'b1;
      tick();
    end
  endtask

  task automatic idle(input int n);
    data_val_i = 1'b0;
    data_i     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    srst = 1'b1;
    dif.deser_data_rdy_i = 1'b1;
    data_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_val_i = (i == 1);
      tick();
    end
    vectors++;
    if (dif.deser_data_val_o !== 1'b0) begin
      $display("FAIL reset_val got %b want 0", dif.deser_data_val_o); miscompares++;
    end
    vectors++;
    if (dif.deser_data_o !== 16'h0000 || dif.deser_data_mod_o !== 4'd0) begin
      $display("FAIL reset_data got %h/%0d want 0/0", dif.deser_data_o, dif.deser_data_mod_o);
      miscompares++;
    end
    vectors++;
    if (frame_err !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL reset_pulses got err=%b ovf=%b want 0/0", frame_err, ovf); miscompares++;
    end
    clear_log();
    srst = 1'b0;
    idle(4);
    vectors++;
    if (q_data.size() != 0 || err_cnt != 0 || ovf_cnt != 0) begin
      $display("FAIL reset_quiet got words=%0d err=%0d ovf=%0d want 0/0/0",
               q_data.size(), err_cnt, ovf_cnt);
      miscompares++;
    end
  endtask

  task automatic test_full_word();
    int last_edge;
    clear_log();
    send_word(16'hA5C3, 16);
    last_edge = cyc;
    idle(3);
    vectors++;
    if (q_data.size() != 1) begin
      $display("FAIL full_count got %0d want 1", q_data.size()); miscompares++;
    end
    if (q_data.size() > 0) begin
      vectors++;
      if (q_data[0] !== 16'hA5C3 || q_mod[0] !== 4'd0) begin
        $display("FAIL full_word got %h/%0d want a5c3/0", q_data[0], q_mod[0]); miscompares++;
      end
      vectors++;
      if (q_cyc[0] != last_edge) begin
        $display("FAIL full_latency got cycle %0d want %0d", q_cyc[0], last_edge); miscompares++;
      end
    end
    vectors++;
    if (val_cycles != 1) begin
      $display("FAIL full_val_width got %0d want 1", val_cycles); miscompares++;
    end
  endtask

  task automatic test_partial();
    int close_edge;
    clear_log();
    send_word(16'hB000, 5);
    idle(3);
    vectors++;
    if (q_data.size() != 1 || (q_data.size() > 0 && (q_data[0] !== 16'hB000 || q_mod[0] !== 4'd5))) begin
      $display("FAIL partial5 got n=%0d %h/%0d want 1 b000/5", q_data.size(),
               (q_data.size() > 0) ? q_data[0] : 16'hxxxx, (q_data.size() > 0) ? q_mod[0] : 4'hx);
      miscompares++;
    end

    clear_log();
    send_word(16'hC000, 2);
    idle(1);
    close_edge = cyc;
    idle(2);
    vectors++;
    if (q_data.size() != 0 || err_cnt != 1) begin
      $display("FAIL short2 got words=%0d err=%0d want 0/1", q_data.size(), err_cnt); miscompares++;
    end
    vectors++;
    if (last_err_cyc != close_edge) begin
      $display("FAIL short2_timing got cycle %0d want %0d", last_err_cyc, close_edge); miscompares++;
    end

    send_word(16'h8000, 1);
    idle(3);
    vectors++;
    if (q_data.size() != 0 || err_cnt != 2) begin
      $display("FAIL short1 got words=%0d err=%0d want 0/2", q_data.size(), err_cnt); miscompares++;
    end

    send_word(16'hA000, 3);
    idle(3);
    vectors++;
    if (q_data.size() != 1 || err_cnt != 2 ||
        (q_data.size() > 0 && (q_data[0] !== 16'hA000 || q_mod[0] !== 4'd3))) begin
      $display("FAIL partial3 got n=%0d err=%0d want 1 a000/3 err 2", q_data.size(), err_cnt);
      miscompares++;
    end

    clear_log();
    send_word(16'hFFFF, 15);
    idle(3);
    vectors++;
    if (q_data.size() != 1 || (q_data.size() > 0 && (q_data[0] !== 16'hFFFE || q_mod[0] !== 4'd15))) begin
      $display("FAIL partial15 got n=%0d %h/%0d want 1 fffe/15", q_data.size(),
               (q_data.size() > 0) ? q_data[0] : 16'hxxxx, (q_data.size() > 0) ? q_mod[0] : 4'hx);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_word(16'hFFFF, 16);
    send_word(16'h0001, 16);
    idle(3);
    vectors++;
    if (q_data.size() != 2) begin
      $display("FAIL b2b_count got %0d want 2", q_data.size()); miscompares++;
    end
    if (q_data.size() == 2) begin
      vectors++;
      if (q_data[0] !== 16'hFFFF || q_mod[0] !== 4'd0 || q_data[1] !== 16'h0001 || q_mod[1] !== 4'd0) begin
        $display("FAIL b2b_words got %h/%0d %h/%0d want ffff/0 0001/0",
                 q_data[0], q_mod[0], q_data[1], q_mod[1]);
        miscompares++;
      end
      vectors++;
      if (q_cyc[1] - q_cyc[0] != 16) begin
        $display("FAIL b2b_spacing got %0d want 16", q_cyc[1] - q_cyc[0]); miscompares++;
      end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    dif.deser_data_rdy_i = 1'b0;
    send_word(16'h1111, 16);
    send_word(16'h2222, 16);
    send_word(16'h3333, 16);
    idle(2);
    vectors++;
    if (ovf_cnt != 1) begin
      $display("FAIL ovf_pulse got %0d want 1", ovf_cnt); miscompares++;
    end
    vectors++;
    if (dif.deser_data_val_o !== 1'b1 || dif.deser_data_o !== 16'h1111) begin
      $display("FAIL ovf_hold got val=%b %h want 1 1111", dif.deser_data_val_o, dif.deser_data_o);
      miscompares++;
    end
    dif.deser_data_rdy_i = 1'b1;
    idle(4);
    vectors++;
    if (q_data.size() != 2 || (q_data.size() == 2 && (q_data[0] !== 16'h1111 || q_data[1] !== 16'h2222))) begin
      $display("FAIL ovf_drain got n=%0d want 2 words 1111 2222", q_data.size()); miscompares++;
    end
    vectors++;
    if (dif.deser_data_val_o !== 1'b0 || dif.deser_data_o !== 16'h0000) begin
      $display("FAIL ovf_empty got val=%b %h want 0 0000", dif.deser_data_val_o, dif.deser_data_o);
      miscompares++;
    end
  endtask

  task automatic test_push_pop_full();
    clear_log();
    dif.deser_data_rdy_i = 1'b0;
    send_word(16'h4444, 16);
    send_word(16'h5555, 16);
    send_word(16'h6666, 15);
    dif.deser_data_rdy_i = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b1;
    tick();
    dif.deser_data_rdy_i = 1'b0;
    idle(2);
    vectors++;
    if (ovf_cnt != 0 || q_data.size() != 1) begin
      $display("FAIL pushpop_ovf got ovf=%0d popped=%0d want 0/1", ovf_cnt, q_data.size());
      miscompares++;
    end
    dif.deser_data_rdy_i = 1'b1;
    idle(4);
    vectors++;
    if (q_data.size() != 3 || (q_data.size() == 3 &&
        (q_data[0] !== 16'h4444 || q_data[1] !== 16'h5555 || q_data[2] !== 16'h6666))) begin
      $display("FAIL pushpop_order got n=%0d want 3 words 4444 5555 6666", q_data.size());
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    dif.deser_data_rdy_i = 1'b0;
    send_word(16'h7777, 16);
    send_word(16'hFFFF, 7);
    srst       = 1'b1;
    data_i     = 1'b1;
    data_val_i = 1'b1;
    tick();
    srst = 1'b0;
    vectors++;
    if (dif.deser_data_val_o !== 1'b0) begin
      $display("FAIL midreset_flush got val=%b want 0", dif.deser_data_val_o); miscompares++;
    end
    idle(3);
    dif.deser_data_rdy_i = 1'b1;
    idle(1);
    send_word(16'h5A69, 16);
    idle(3);
    vectors++;
    if (q_data.size() != 1 || err_cnt != 0 ||
        (q_data.size() > 0 && (q_data[0] !== 16'h5A69 || q_mod[0] !== 4'd0))) begin
      $display("FAIL midreset_next got n=%0d err=%0d want 1 word 5a69/0", q_data.size(), err_cnt);
      miscompares++;
    end
  endtask

  initial begin
    data_i     = 1'b0;
    data_val_i = 1'b0;
    zero_viol  = 0;
    clear_log();
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    vectors++;
    if (zero_viol != 0) begin
      $display("FAIL idle_zero got %0d nonzero idle cycles want 0", zero_viol); miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning maximum word length in bits.
REQ-002 SHALL have derived parameter W_INDEX = $clog2(WIDTH), default 4, meaning width of the length field.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port srst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port data_i  input  1  serial data bit, MSB of the word first.
REQ-006 SHALL have port data_val_i  input  1  data_i valid this cycle.
REQ-007 SHALL have port deser_data_o  output  WIDTH  received word, MSB-aligned.
REQ-008 SHALL have port deser_data_mod_o  output  W_INDEX  valid-bit count; 0 means WIDTH bits.
REQ-009 SHALL have port deser_data_val_o  output  1  word available on deser_data_o/deser_data_mod_o.
REQ-010 SHALL have port deser_data_rdy_i  input  1  consumer accepts the word when high together with deser_data_val_o.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse: a 1- or 2-bit frame was discarded.
REQ-012 SHALL have port ovf_o  output  1  one-cycle pulse: a completed word was dropped because the output buffer was full.

Function
REQ-013 SHALL sample data_i on every rising edge where data_val_i=1; the first bit of a frame goes to word bit WIDTH-1, subsequent bits to descending positions.
REQ-014 SHALL define a frame as a run of consecutive data_val_i=1 cycles, capped at WIDTH bits.
REQ-015 SHALL use a two-state FSM: IDLE (bit counter 0) and RECV (1..WIDTH-1 bits held); IDLE->RECV on a sampled bit, RECV->IDLE on frame close.
REQ-016 SHALL close a frame on the edge where the WIDTH-th bit is sampled (full word, mod=0); a further contiguous valid bit on the next edge starts a new frame.
REQ-017 SHALL close a frame on the first edge where data_val_i=0 in RECV; mod = bit count, unreceived low bits = 0.
REQ-018 SHALL discard frames of 1 or 2 bits (mod 1/2 are illegal) and pulse frame_err_o high for exactly the cycle after the closing edge.
REQ-019 SHALL push each closed legal word into a 2-entry FIFO on the closing edge; deser_data_val_o SHALL rise in the cycle immediately after that edge when the FIFO was empty (latency 1 cycle).
REQ-020 SHALL present the FIFO head on deser_data_o/deser_data_mod_o, holding it stable while deser_data_val_o=1 and deser_data_rdy_i=0.
REQ-021 SHALL pop the head on an edge where deser_data_val_o=1 and deser_data_rdy_i=1; words SHALL leave in arrival order.
REQ-022 SHALL, on a simultaneous pop and push with FIFO full, accept the push (no overflow).
REQ-023 SHALL, on a push with FIFO full and no pop, drop the new word, keep FIFO contents, and pulse ovf_o for one cycle.
REQ-024 SHALL drive deser_data_o and deser_data_mod_o to 0 whenever deser_data_val_o=0.
REQ-025 SHALL accept a new serial bit on every cycle, including closing and push cycles; no input back-pressure exists.

Reset
REQ-026 SHALL, while srst_i=1 on a rising edge, set FSM to IDLE, bit counter to 0, shift register to 0, FIFO empty.
REQ-027 SHALL hold deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, frame_err_o=0, ovf_o=0 in the cycle after a reset edge.
REQ-028 SHALL discard any partial frame and buffered words on reset mid-operation; data_val_i during reset SHALL be ignored.
REQ-029 SHALL take precedence over all other activity on the same edge.

Verification
REQ-030 Reset: srst_i high 2 cycles with data_val_i=1 toggling -> all outputs 0, no word emitted after release.
REQ-031 Full word: 16 contiguous bits of 16'hA5C3 MSB first, rdy=1 -> one word 16'hA5C3, mod 0, val high exactly one cycle, one cycle after last bit edge.
REQ-032 Partial: bits 1,0,1,1,0 then data_val_i=0 -> word 16'hB000, mod 5; 2-bit frame 1,1 -> no word, frame_err_o pulsed once.
REQ-033 Back-to-back: 32 contiguous bits 16'hFFFF then 16'h0001 -> two words in order, both mod 0, no gap required at input.
REQ-034 Overflow: rdy=0, three full frames -> first two held, third dropped with single ovf_o pulse; then rdy=1 -> first, second drained in order.
REQ-035 Reset mid-frame: srst_i pulsed after 7 of 16 bits -> no word emitted; next clean 16-bit frame received correctly.
